// File: rtl/jk_bank_seq_pkg.sv
// Shared definitions for the JK bank command sequencer.
// Optional build macro: JK_BANK_SEQ_SYNC_SET_EN (SET through the bank's sync set).
package jk_bank_seq_pkg;

    localparam int OP_W = 3;

    localparam logic [OP_W-1:0] OP_NOP    = 3'd0;
    localparam logic [OP_W-1:0] OP_CLEAR  = 3'd1;
    localparam logic [OP_W-1:0] OP_SET    = 3'd2;
    localparam logic [OP_W-1:0] OP_TOGGLE = 3'd3;
    localparam logic [OP_W-1:0] OP_LOAD   = 3'd4;
    localparam logic [OP_W-1:0] OP_CNT_UP = 3'd5;
    localparam logic [OP_W-1:0] OP_CNT_DN = 3'd6;
    localparam logic [OP_W-1:0] OP_SHL    = 3'd7;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Opcodes whose step count comes from the command; the rest run once.
    function automatic logic op_repeats(input logic [OP_W-1:0] op);
        return (op == OP_TOGGLE) || (op == OP_CNT_UP) ||
               (op == OP_CNT_DN) || (op == OP_SHL);
    endfunction

endpackage

// File: rtl/jk_bank_drive.sv
// Combinational j/k (and sync-set request) generation for one step of a bank op.
// Optional build macro: JK_BANK_SEQ_SYNC_SET_EN (SET requests the bank's sync set).
module jk_bank_drive
    import jk_bank_seq_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic [OP_W-1:0]  op,
    input  logic [WIDTH-1:0] arg,
    input  logic [WIDTH-1:0] q_vec,
    output logic [WIDTH-1:0] j_vec,
    output logic [WIDTH-1:0] k_vec,
    output logic             setlow_req
);

    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    // Bits that flip on +1 / -1 are exactly the counter toggle masks.
    logic [WIDTH-1:0] up_mask;
    logic [WIDTH-1:0] dn_mask;
    logic [WIDTH-1:0] shl_d;

    assign up_mask = q_vec ^ (q_vec + ONE);
    assign dn_mask = q_vec ^ (q_vec - ONE);
    assign shl_d   = {q_vec[WIDTH-2:0], arg[0]};

    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_bit
            logic j_bit;
            logic k_bit;

            // Per-bit j/k selection for the captured opcode.
            always_comb begin
                j_bit = 1'b0;
                k_bit = 1'b0;
                case (op)
                    OP_CLEAR: k_bit = 1'b1;
                    OP_SET: begin
`ifdef JK_BANK_SEQ_SYNC_SET_EN
                        // Bank is forced high by setlow; hold j/k idle.
                        j_bit = 1'b0;
`else
                        j_bit = 1'b1;
`endif
                    end
                    OP_TOGGLE: begin
                        j_bit = 1'b1;
                        k_bit = 1'b1;
                    end
                    OP_LOAD: begin
                        j_bit = arg[gi];
                        k_bit = ~arg[gi];
                    end
                    OP_CNT_UP: begin
                        j_bit = up_mask[gi];
                        k_bit = up_mask[gi];
                    end
                    OP_CNT_DN: begin
                        j_bit = dn_mask[gi];
                        k_bit = dn_mask[gi];
                    end
                    OP_SHL: begin
                        j_bit = shl_d[gi];
                        k_bit = ~shl_d[gi];
                    end
                    default: ;
                endcase
            end

            assign j_vec[gi] = j_bit;
            assign k_vec[gi] = k_bit;
        end
    endgenerate

`ifdef JK_BANK_SEQ_SYNC_SET_EN
    assign setlow_req = (op == OP_SET);
`else
    assign setlow_req = 1'b0;
`endif

endmodule

// File: rtl/jk_bank_seq.sv
// Command sequencer for an external bank of JK cells: handshake, FSM, step counter.
// Optional build macro: JK_BANK_SEQ_SYNC_SET_EN (SET uses the bank's sync active-low set).
module jk_bank_seq
    import jk_bank_seq_pkg::*;
#(
    parameter int WIDTH  = 4,
    parameter int STEP_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [OP_W-1:0]   cmd_op,
    input  logic [WIDTH-1:0]  cmd_arg,
    input  logic [STEP_W-1:0] cmd_steps,
    input  logic [WIDTH-1:0]  q_vec,
    output logic [WIDTH-1:0]  j_vec,
    output logic [WIDTH-1:0]  k_vec,
    output logic              setlow,
    output logic              busy,
    output logic              done
);

    state_t            state_reg;
    logic [OP_W-1:0]   op_reg;
    logic [WIDTH-1:0]  arg_reg;
    logic [STEP_W-1:0] remaining_reg;

    logic [STEP_W-1:0] steps_init;
    logic              run;
    logic [WIDTH-1:0]  drv_j;
    logic [WIDTH-1:0]  drv_k;
    logic              drv_setlow_req;

    assign steps_init = op_repeats(cmd_op) ? cmd_steps : STEP_W'(1);
    assign run        = (state_reg == ST_RUN);

    jk_bank_drive #(
        .WIDTH (WIDTH)
    ) u_drive (
        .op         (op_reg),
        .arg        (arg_reg),
        .q_vec      (q_vec),
        .j_vec      (drv_j),
        .k_vec      (drv_k),
        .setlow_req (drv_setlow_req)
    );

    // The bank holds whenever no step is being executed.
    assign j_vec  = run ? drv_j : '0;
    assign k_vec  = run ? drv_k : '0;
    assign setlow = ~(run & drv_setlow_req);

    // Command FSM: capture in IDLE, step in RUN, one-cycle done pulse in DONE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg     <= ST_IDLE;
            op_reg        <= OP_NOP;
            arg_reg       <= '0;
            remaining_reg <= '0;
            cmd_ready     <= 1'b1;
            busy          <= 1'b0;
            done          <= 1'b0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (cmd_valid && cmd_ready) begin
                        op_reg        <= cmd_op;
                        arg_reg       <= cmd_arg;
                        remaining_reg <= steps_init;
                        cmd_ready     <= 1'b0;
                        if ((cmd_op == OP_NOP) || (steps_init == '0)) begin
                            state_reg <= ST_DONE;
                            done      <= 1'b1;
                        end else begin
                            state_reg <= ST_RUN;
                            busy      <= 1'b1;
                        end
                    end
                end
                ST_RUN: begin
                    remaining_reg <= remaining_reg - STEP_W'(1);
                    if (remaining_reg == STEP_W'(1)) begin
                        state_reg <= ST_DONE;
                        busy      <= 1'b0;
                        done      <= 1'b1;
                    end
                end
                ST_DONE: begin
                    state_reg <= ST_IDLE;
                    done      <= 1'b0;
                    cmd_ready <= 1'b1;
                end
                default: begin
                    state_reg <= ST_IDLE;
                    busy      <= 1'b0;
                    done      <= 1'b0;
                    cmd_ready <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_jk_bank_seq.sv
// Scoreboard bench for jk_bank_seq with a behavioural JK bank attached.
`timescale 1ns/1ps
module tb_jk_bank_seq;
    import jk_bank_seq_pkg::*;

    localparam int W  = 4;
    localparam int SW = 8;
`ifdef JK_BANK_SEQ_SYNC_SET_EN
    localparam int SYNC_SET = 1;
`else
    localparam int SYNC_SET = 0;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic          cmd_valid;
    logic          cmd_ready;
    logic [2:0]    cmd_op;
    logic [W-1:0]  cmd_arg;
    logic [SW-1:0] cmd_steps;
    logic [W-1:0]  bank_q;
    logic [W-1:0]  j_vec;
    logic [W-1:0]  k_vec;
    logic          setlow;
    logic          busy;
    logic          done;

    always #5 clk = ~clk;

    jk_bank_seq #(.WIDTH(W), .STEP_W(SW)) dut (
        .clk       (clk),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_arg   (cmd_arg),
        .cmd_steps (cmd_steps),
        .q_vec     (bank_q),
        .j_vec     (j_vec),
        .k_vec     (k_vec),
        .setlow    (setlow),
        .busy      (busy),
        .done      (done)
    );

    // Behavioural JK bank sharing clk/rst, with sync active-low set.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)          bank_q <= '0;
        else if (!setlow) bank_q <= '1;
        else              bank_q <= (j_vec & ~bank_q) | (~k_vec & bank_q);
    end

    typedef struct {
        logic [W-1:0] q;
        int           n;
        int           lows;
        logic [2:0]   op;
    } txn_t;

    int           errors = 0;
    int           checks = 0;
    txn_t         txn_q[$];
    logic [W-1:0] step_q[$];
    logic [W-1:0] model_q;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h expected=%0h", name, got, exp);
        end
    endtask

    // Reference: effect of one step of an op on the bank value.
    function automatic logic [W-1:0] ref_step(input logic [2:0] op, input logic [W-1:0] arg,
                                              input logic [W-1:0] q);
        case (op)
            OP_CLEAR:  return '0;
            OP_SET:    return '1;
            OP_TOGGLE: return ~q;
            OP_LOAD:   return arg;
            OP_CNT_UP: return q + W'(1);
            OP_CNT_DN: return q - W'(1);
            OP_SHL:    return {q[W-2:0], arg[0]};
            default:   return q;
        endcase
    endfunction

    function automatic int ref_count(input logic [2:0] op, input logic [SW-1:0] steps);
        if (op == OP_NOP) return 0;
        if (op inside {OP_TOGGLE, OP_CNT_UP, OP_CNT_DN, OP_SHL}) return int'(steps);
        return 1;
    endfunction

    // Issue one command; expectations go to the scoreboard before the accept edge.
    // Enter and leave at posedge+1.
    task automatic send(input logic [2:0] op, input logic [W-1:0] arg, input logic [SW-1:0] steps);
        txn_t t;
        int   guard;
        int   n;
        guard = 0;
        while (!cmd_ready && guard < 300) begin
            @(posedge clk); #1;
            guard++;
        end
        if (!cmd_ready) begin
            checks++;
            errors++;
            $display("FAIL ready_timeout op=%0d got=0 expected=1", op);
            return;
        end
        n = ref_count(op, steps);
        for (int s = 0; s < n; s++) begin
            model_q = ref_step(op, arg, model_q);
            step_q.push_back(model_q);
        end
        t.q    = model_q;
        t.n    = n;
        t.lows = (op == OP_SET && SYNC_SET == 1) ? 1 : 0;
        t.op   = op;
        txn_q.push_back(t);
        $display("cmd op=%0d arg=%b steps=%0d expect_q=%b cycles=%0d", op, arg, steps, t.q, n);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_arg   = arg;
        cmd_steps = steps;
        @(posedge clk); #1;
        // Stray command while not ready must be ignored.
        cmd_valid = 1'($urandom_range(0, 1));
        cmd_op    = 3'($urandom);
        cmd_arg   = W'($urandom);
        cmd_steps = SW'($urandom);
        @(posedge clk); #1;
        cmd_valid = 1'b0;
    endtask

    // Monitor: per-step bank values, idle outputs, and end-of-command totals.
    int           busy_cnt  = 0;
    int           low_cnt   = 0;
    logic         busy_seen = 1'b0;
    logic [W-1:0] mon_e;
    txn_t         mon_t;
    int           done_seen = 0;

    always @(negedge clk) begin
        if (rst) begin
            busy_cnt  = 0;
            low_cnt   = 0;
            busy_seen = 1'b0;
        end else begin
            if (busy_seen) begin
                if (step_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_step got=%b expected=no_step", bank_q);
                end else begin
                    mon_e = step_q.pop_front();
                    check("step_q", 32'(bank_q), 32'(mon_e));
                end
            end
            if (!busy) begin
                check("idle_j", 32'(j_vec), 32'(0));
                check("idle_k", 32'(k_vec), 32'(0));
                check("idle_setlow", 32'(setlow), 32'(1));
            end
            if (busy) busy_cnt++;
            if (!setlow) low_cnt++;
            if (done) begin
                done_seen++;
                check("done_ready_low", 32'(cmd_ready), 32'(0));
                check("done_busy_low", 32'(busy), 32'(0));
                if (txn_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_done got=1 expected=0");
                end else begin
                    mon_t = txn_q.pop_front();
                    $display("done op=%0d q=%b expect=%b busy_cycles=%0d", mon_t.op, bank_q, mon_t.q, busy_cnt);
                    check("final_q", 32'(bank_q), 32'(mon_t.q));
                    check("busy_cycles", 32'(busy_cnt), 32'(mon_t.n));
                    check("setlow_cycles", 32'(low_cnt), 32'(mon_t.lows));
                end
                busy_cnt = 0;
                low_cnt  = 0;
            end
            busy_seen = busy;
        end
    end

    task automatic drain();
        int guard;
        guard = 0;
        while ((txn_q.size() != 0 || !cmd_ready) && guard < 600) begin
            @(posedge clk); #1;
            guard++;
        end
        check("drain_txn_left", 32'(txn_q.size()), 32'(0));
        check("drain_step_left", 32'(step_q.size()), 32'(0));
    endtask

    initial begin
        int done_before;
        rst       = 1'b1;
        cmd_valid = 1'b0;
        cmd_op    = OP_NOP;
        cmd_arg   = '0;
        cmd_steps = '0;
        model_q   = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_ready", 32'(cmd_ready), 32'(1));
        check("rst_busy", 32'(busy), 32'(0));
        check("rst_done", 32'(done), 32'(0));
        check("rst_j", 32'(j_vec), 32'(0));
        check("rst_k", 32'(k_vec), 32'(0));
        check("rst_setlow", 32'(setlow), 32'(1));
        check("rst_bank", 32'(bank_q), 32'(0));
        rst = 1'b0;
        @(posedge clk); #1;

        // Directed scenarios from the plan.
        send(OP_LOAD,   4'b1010, 8'd0);
        send(OP_LOAD,   4'b1110, 8'd5);
        send(OP_CNT_UP, 4'b0000, 8'd3);
        send(OP_CLEAR,  4'b1111, 8'd9);
        send(OP_CNT_DN, 4'b0000, 8'd2);
        send(OP_LOAD,   4'b0001, 8'd1);
        send(OP_SHL,    4'b0001, 8'd2);
        send(OP_CLEAR,  4'b0000, 8'd1);
        send(OP_SET,    4'b0000, 8'd7);
        send(OP_NOP,    4'b0101, 8'd4);
        send(OP_TOGGLE, 4'b0000, 8'd4);
        send(OP_TOGGLE, 4'b0000, 8'd0);
        send(OP_CNT_UP, 4'b0000, 8'd20);
        send(OP_SHL,    4'b0000, 8'd3);
        drain();

        // Randomized commands.
        for (int i = 0; i < 40; i++) begin
            send(3'($urandom_range(0, 7)), W'($urandom), SW'($urandom_range(0, 12)));
        end
        drain();

        // Reset in the fourth RUN cycle of a long toggle.
        send(OP_TOGGLE, 4'b0000, 8'd10);
        repeat (2) @(posedge clk);
        #1;
        check("pre_rst_busy", 32'(busy), 32'(1));
        done_before = done_seen;
        rst = 1'b1;
        txn_q.delete();
        step_q.delete();
        model_q = '0;
        #1;
        check("midrst_bank", 32'(bank_q), 32'(0));
        check("midrst_busy", 32'(busy), 32'(0));
        check("midrst_done", 32'(done), 32'(0));
        check("midrst_ready", 32'(cmd_ready), 32'(1));
        check("midrst_j", 32'(j_vec), 32'(0));
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (12) @(posedge clk);
        #1;
        check("postrst_ready", 32'(cmd_ready), 32'(1));
        check("postrst_busy", 32'(busy), 32'(0));
        check("postrst_no_done", 32'(done_seen), 32'(done_before));
        check("postrst_bank", 32'(bank_q), 32'(0));

        // Sequencer still works after the reset.
        send(OP_CNT_DN, 4'b0000, 8'd1);
        send(OP_LOAD,   4'b0110, 8'd0);
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
